// File: rtl/fp_add_subt_pkg.sv
// Shared definitions for the single-precision add/subtract unit.
// Holds the FSM state encoding, default field widths and the packed
// special-value constants for the default (IEEE-754 single) format.
package fp_add_subt_pkg;

    localparam int EW_DEF = 8;
    localparam int SW_DEF = 23;

    localparam logic [EW_DEF-1:0]      EXP_MAX  = {EW_DEF{1'b1}};
    localparam logic [EW_DEF+SW_DEF:0] INF_POS  = {1'b0, EXP_MAX, {SW_DEF{1'b0}}};
    localparam logic [EW_DEF+SW_DEF:0] ZERO_POS = {(EW_DEF+SW_DEF+1){1'b0}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMP   = 3'd1,
        ALIGN = 3'd2,
        ADD   = 3'd3,
        NORM  = 3'd4,
        DONE  = 3'd5
    } state_e;

endpackage

// File: rtl/fp_add_subt_unit_sgf_add_subt.sv
// sgf_add_subt: combinational magnitude comparator and significand
// adder/subtractor for fp_add_subt_unit.
// Ports:
//   exp_x_i, exp_y_i : biased exponents of X and Y
//   sig_x_i, sig_y_i : significands with hidden bit (zero when flushed)
//   sig_a_i, sig_b_i : aligned larger / smaller significands
//   sub_i            : 1 = subtract sig_b_i from sig_a_i
//   x_ge_y_o         : |X| >= |Y| (exponent first, then significand)
//   sum_o            : sig_a_i +/- sig_b_i, carry in the top bit
module sgf_add_subt #(
    parameter int EW = 8,
    parameter int SW = 23
) (
    input  logic [EW-1:0] exp_x_i,
    input  logic [EW-1:0] exp_y_i,
    input  logic [SW+1:0] sig_x_i,
    input  logic [SW+1:0] sig_y_i,
    input  logic [SW+1:0] sig_a_i,
    input  logic [SW+1:0] sig_b_i,
    input  logic          sub_i,
    output logic          x_ge_y_o,
    output logic [SW+1:0] sum_o
);

    // Concatenating exponent above significand gives magnitude order directly.
    assign x_ge_y_o = ({exp_x_i, sig_x_i} >= {exp_y_i, sig_y_i});

    // A >= B is guaranteed upstream, so the difference never wraps.
    assign sum_o = sub_i ? (sig_a_i - sig_b_i) : (sig_a_i + sig_b_i);

endmodule

// File: rtl/fp_add_subt_unit.sv
// fp_add_subt_unit: multi-cycle single-precision add/subtract, responder
// side of the beg/ready/ack handshake. Operands are latched on a begin
// pulse, aligned one bit per cycle, added, normalised one step per cycle
// and truncated. The result is held with ready high until acknowledged.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   beg_add_subt        : start request (IDLE only)
//   ack_add_subt        : result consumed (DONE only)
//   add_subt            : 0 = X+Y, 1 = X-Y
//   Data_X, Data_Y      : operands
//   ready_add_subt      : result valid
//   result              : sum or difference
//   overflow_flag       : exponent overflow or Inf/NaN operand
//   underflow_flag      : result flushed to zero on exponent underflow
module fp_add_subt_unit
    import fp_add_subt_pkg::*;
#(
    parameter int EW = EW_DEF,
    parameter int SW = SW_DEF,
    localparam int W = EW + SW + 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         beg_add_subt,
    input  logic         ack_add_subt,
    input  logic         add_subt,
    input  logic [W-1:0] Data_X,
    input  logic [W-1:0] Data_Y,
    output logic         ready_add_subt,
    output logic [W-1:0] result,
    output logic         overflow_flag,
    output logic         underflow_flag
);

    localparam logic [EW-1:0] EXP_ONES  = {EW{1'b1}};
    localparam logic [EW-1:0] EXP_ZERO  = {EW{1'b0}};
    localparam logic [EW-1:0] EXP_ONE   = {{(EW-1){1'b0}}, 1'b1};
    localparam logic [EW-1:0] EXP_TOP   = EXP_ONES - EXP_ONE;
    localparam logic [EW-1:0] DIFF_CLR  = EW'(SW + 2);
    localparam logic [SW-1:0] FRAC_ZERO = {SW{1'b0}};
    localparam logic [SW+1:0] SIG_ZERO  = {(SW+2){1'b0}};
    localparam logic [W-2:0]  MAG_ZERO  = {(W-1){1'b0}};

    state_e        state_q, state_d;
    logic [W-1:0]  x_q, x_d;
    logic [W-1:0]  y_q, y_d;
    logic          op_q, op_d;
    logic          sign_q, sign_d;
    logic          eff_sub_q, eff_sub_d;
    logic [EW-1:0] exp_q, exp_d;
    logic [EW-1:0] diff_q, diff_d;
    logic [SW+1:0] sig_a_q, sig_a_d;
    logic [SW+1:0] sig_b_q, sig_b_d;
    logic [W-1:0]  result_q, result_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          ready_q, ready_d;

    logic          sx_s, sy_s;
    logic [EW-1:0] ex_s, ey_s;
    logic [SW+1:0] sig_x_s, sig_y_s;
    logic          x_ge_y_s;
    logic [SW+1:0] sum_s;

    assign sx_s = x_q[W-1];
    assign sy_s = y_q[W-1];
    assign ex_s = x_q[W-2:SW];
    assign ey_s = y_q[W-2:SW];

    // A zero exponent flushes the operand (zero or denormal) to a zero significand.
    assign sig_x_s = (ex_s == EXP_ZERO) ? SIG_ZERO : {2'b01, x_q[SW-1:0]};
    assign sig_y_s = (ey_s == EXP_ZERO) ? SIG_ZERO : {2'b01, y_q[SW-1:0]};

    sgf_add_subt #(
        .EW (EW),
        .SW (SW)
    ) u_sgf (
        .exp_x_i  (ex_s),
        .exp_y_i  (ey_s),
        .sig_x_i  (sig_x_s),
        .sig_y_i  (sig_y_s),
        .sig_a_i  (sig_a_q),
        .sig_b_i  (sig_b_q),
        .sub_i    (eff_sub_q),
        .x_ge_y_o (x_ge_y_s),
        .sum_o    (sum_s)
    );

    // Next-state and datapath update for the add/subtract sequence.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        op_d      = op_q;
        sign_d    = sign_q;
        eff_sub_d = eff_sub_q;
        exp_d     = exp_q;
        diff_d    = diff_q;
        sig_a_d   = sig_a_q;
        sig_b_d   = sig_b_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        ready_d   = ready_q;

        case (state_q)
            IDLE: begin
                if (beg_add_subt) begin
                    x_d     = Data_X;
                    y_d     = Data_Y;
                    op_d    = add_subt;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    state_d = CMP;
                end else begin
                    state_d = IDLE;
                end
            end

            CMP: begin
                if (ex_s == EXP_ONES) begin
                    result_d = {sx_s, EXP_ONES, FRAC_ZERO};
                    ovf_d    = 1'b1;
                    ready_d  = 1'b1;
                    state_d  = DONE;
                end else if (ey_s == EXP_ONES) begin
                    result_d = {sy_s ^ op_q, EXP_ONES, FRAC_ZERO};
                    ovf_d    = 1'b1;
                    ready_d  = 1'b1;
                    state_d  = DONE;
                end else if (x_ge_y_s) begin
                    sign_d    = sx_s;
                    exp_d     = ex_s;
                    diff_d    = ex_s - ey_s;
                    sig_a_d   = sig_x_s;
                    sig_b_d   = sig_y_s;
                    eff_sub_d = op_q ^ sx_s ^ sy_s;
                    state_d   = ALIGN;
                end else begin
                    // Y is the larger operand; its sign flips for X-Y.
                    sign_d    = sy_s ^ op_q;
                    exp_d     = ey_s;
                    diff_d    = ey_s - ex_s;
                    sig_a_d   = sig_y_s;
                    sig_b_d   = sig_x_s;
                    eff_sub_d = op_q ^ sx_s ^ sy_s;
                    state_d   = ALIGN;
                end
            end

            ALIGN: begin
                if (diff_q == EXP_ZERO) begin
                    state_d = ADD;
                end else if (diff_q >= DIFF_CLR) begin
                    // Every significant bit would be shifted out anyway.
                    sig_b_d = SIG_ZERO;
                    diff_d  = EXP_ZERO;
                end else begin
                    sig_b_d = {1'b0, sig_b_q[SW+1:1]};
                    diff_d  = diff_q - EXP_ONE;
                end
            end

            ADD: begin
                sig_a_d = sum_s;
                state_d = NORM;
            end

            NORM: begin
                if (sig_a_q == SIG_ZERO) begin
                    result_d = {1'b0, MAG_ZERO};
                    ready_d  = 1'b1;
                    state_d  = DONE;
                end else if (sig_a_q[SW+1]) begin
                    sig_a_d = {1'b0, sig_a_q[SW+1:1]};
                    exp_d   = exp_q + EXP_ONE;
                    if (exp_q == EXP_TOP) begin
                        result_d = {sign_q, EXP_ONES, FRAC_ZERO};
                        ovf_d    = 1'b1;
                        ready_d  = 1'b1;
                        state_d  = DONE;
                    end else begin
                        state_d = NORM;
                    end
                end else if (!sig_a_q[SW]) begin
                    sig_a_d = {sig_a_q[SW:0], 1'b0};
                    exp_d   = exp_q - EXP_ONE;
                    if (exp_q == EXP_ONE) begin
                        result_d = {sign_q, MAG_ZERO};
                        unf_d    = 1'b1;
                        ready_d  = 1'b1;
                        state_d  = DONE;
                    end else begin
                        state_d = NORM;
                    end
                end else begin
                    result_d = {sign_q, exp_q, sig_a_q[SW-1:0]};
                    ready_d  = 1'b1;
                    state_d  = DONE;
                end
            end

            DONE: begin
                if (ack_add_subt) begin
                    ready_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end

            default: begin
                state_d = IDLE;
                ready_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            x_q       <= {W{1'b0}};
            y_q       <= {W{1'b0}};
            op_q      <= 1'b0;
            sign_q    <= 1'b0;
            eff_sub_q <= 1'b0;
            exp_q     <= EXP_ZERO;
            diff_q    <= EXP_ZERO;
            sig_a_q   <= SIG_ZERO;
            sig_b_q   <= SIG_ZERO;
            result_q  <= {W{1'b0}};
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            op_q      <= op_d;
            sign_q    <= sign_d;
            eff_sub_q <= eff_sub_d;
            exp_q     <= exp_d;
            diff_q    <= diff_d;
            sig_a_q   <= sig_a_d;
            sig_b_q   <= sig_b_d;
            result_q  <= result_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            ready_q   <= ready_d;
        end
    end

    assign ready_add_subt = ready_q;
    assign result         = result_q;
    assign overflow_flag  = ovf_q;
    assign underflow_flag = unf_q;

endmodule

// File: tb/tb_fp_add_subt_unit.sv
// Self-checking bench for fp_add_subt_unit: directed vectors, randomized
// operands against a behavioural model, handshake and reset scenarios.
module tb_fp_add_subt_unit;
    import fp_add_subt_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        beg_add_subt = 1'b0;
    logic        ack_add_subt = 1'b0;
    logic        add_subt = 1'b0;
    logic [31:0] Data_X = 32'h0;
    logic [31:0] Data_Y = 32'h0;
    logic        ready_add_subt;
    logic [31:0] result;
    logic        overflow_flag;
    logic        underflow_flag;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fp_add_subt_unit dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .beg_add_subt   (beg_add_subt),
        .ack_add_subt   (ack_add_subt),
        .add_subt       (add_subt),
        .Data_X         (Data_X),
        .Data_Y         (Data_Y),
        .ready_add_subt (ready_add_subt),
        .result         (result),
        .overflow_flag  (overflow_flag),
        .underflow_flag (underflow_flag)
    );

    // Reference: integer arithmetic on unpacked fields, truncating alignment,
    // then normalisation; latency counted as CMP + ALIGN + ADD + NORM steps.
    function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                  input logic op, output logic [31:0] r,
                                  output logic ovf, output logic unf, output int lat);
        int     ex, ey, ea, eb, d;
        longint mx, my, sa, sb, s;
        logic   sx, sy, sgn, eff;
        sx = x[31]; sy = y[31];
        ex = int'(x[30:23]); ey = int'(y[30:23]);
        ovf = 1'b0; unf = 1'b0;
        if (ex == int'(EXP_MAX)) begin
            r = INF_POS | {sx, 31'h0}; ovf = 1'b1; lat = 1; return;
        end
        if (ey == int'(EXP_MAX)) begin
            r = INF_POS | {sy ^ op, 31'h0}; ovf = 1'b1; lat = 1; return;
        end
        mx = (ex == 0) ? 64'sd0 : (64'sd8388608 + longint'(x[22:0]));
        my = (ey == 0) ? 64'sd0 : (64'sd8388608 + longint'(y[22:0]));
        if (ex > ey || (ex == ey && mx >= my)) begin
            ea = ex; sa = mx; eb = ey; sb = my; sgn = sx;
        end else begin
            ea = ey; sa = my; eb = ex; sb = mx; sgn = sy ^ op;
        end
        d   = ea - eb;
        lat = 1 + ((d >= 25) ? 2 : d + 1) + 1;
        sb  = (d >= 25) ? 64'sd0 : (sb >>> d);
        eff = op ^ sx ^ sy;
        s   = eff ? (sa - sb) : (sa + sb);
        if (s == 0) begin
            r = ZERO_POS; lat = lat + 1; return;
        end
        if (s >= 64'sd16777216) begin
            lat = lat + 1; s = s >>> 1; ea = ea + 1;
            if (ea == 255) begin
                r = INF_POS | {sgn, 31'h0}; ovf = 1'b1; return;
            end
        end
        while (s < 64'sd8388608) begin
            lat = lat + 1; s = s <<< 1; ea = ea - 1;
            if (ea == 0) begin
                r = {sgn, 31'h0}; unf = 1'b1; return;
            end
        end
        lat = lat + 1;
        r = {sgn, 8'(ea), 23'(s)};
    endfunction

    // Present a request; returns just after the edge that samples it.
    task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic op);
        @(negedge clk);
        Data_X = x; Data_Y = y; add_subt = op; beg_add_subt = 1'b1;
        @(posedge clk); #1;
        beg_add_subt = 1'b0;
    endtask

    // Count edges until ready rises; -1 if it never does within the budget.
    task automatic wait_ready(output int cycles);
        cycles = -1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (ready_add_subt === 1'b1) begin
                cycles = c;
                return;
            end
        end
    endtask

    task automatic do_ack();
        @(negedge clk); ack_add_subt = 1'b1;
        @(posedge clk); #1; ack_add_subt = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({ready_add_subt, result, overflow_flag, underflow_flag} !== 35'h0) begin
            n_fail++;
            $display("FAIL reset_state: got ready=%b result=%h ovf=%b unf=%b, expected all zero",
                     ready_add_subt, result, overflow_flag, underflow_flag);
        end
        @(negedge clk); reset_n = 1'b1;
    endtask

    localparam int ND = 8;
    localparam logic [31:0] DX  [ND] = '{32'h3FC00000, 32'h40A00000, 32'h3F800000, 32'h7F7FFFFF,
                                         32'h3F800000, 32'h7FC00000, 32'h3F800000, 32'h00800001};
    localparam logic [31:0] DY  [ND] = '{32'h40100000, 32'h40A00000, 32'h3F400000, 32'h7F7FFFFF,
                                         32'h30800000, 32'h3F800000, 32'h7F800000, 32'h00800000};
    localparam logic        DOP [ND] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    localparam logic [31:0] DR  [ND] = '{32'h40700000, 32'h00000000, 32'h3E800000, 32'h7F800000,
                                         32'h3F800000, 32'h7F800000, 32'hFF800000, 32'h00000000};
    localparam logic        DOV [ND] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam logic        DUN [ND] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    task automatic test_directed();
        logic [31:0] r_m; logic o_m, u_m; int lat_m, lat;
        for (int i = 0; i < ND; i++) begin
            model(DX[i], DY[i], DOP[i], r_m, o_m, u_m, lat_m);
            start_op(DX[i], DY[i], DOP[i]);
            n_checks++;
            if ({overflow_flag, underflow_flag} !== 2'b00) begin
                n_fail++;
                $display("FAIL dir%0d_flags_cleared: got %b%b expected 00", i, overflow_flag, underflow_flag);
            end
            wait_ready(lat);
            n_checks++;
            if (lat !== lat_m) begin
                n_fail++;
                $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, lat_m);
            end
            n_checks++;
            if (result !== DR[i]) begin
                n_fail++;
                $display("FAIL dir%0d_result: got %h expected %h", i, result, DR[i]);
            end
            n_checks++;
            if ({overflow_flag, underflow_flag} !== {DOV[i], DUN[i]}) begin
                n_fail++;
                $display("FAIL dir%0d_flags: got %b%b expected %b%b", i, overflow_flag,
                         underflow_flag, DOV[i], DUN[i]);
            end
            do_ack();
            n_checks++;
            if (ready_add_subt !== 1'b0 || result !== DR[i]) begin
                n_fail++;
                $display("FAIL dir%0d_after_ack: got ready=%b result=%h expected 0 %h", i,
                         ready_add_subt, result, DR[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] x, y, r_m; logic op, o_m, u_m; int lat_m, lat, mode;
        for (int i = 0; i < 300; i++) begin
            x = $urandom; y = $urandom; op = 1'($urandom_range(0, 1));
            mode = $urandom_range(0, 5);
            case (mode)
                1: begin
                    x[30:23] = 8'($urandom_range(1, 250));
                    y[30:23] = x[30:23] + 8'($urandom_range(0, 4));
                end
                2: begin
                    x[30:23] = 8'($urandom_range(1, 3));
                    y = x ^ 32'($urandom_range(0, 255));
                    op = 1'b1;
                end
                3: begin
                    x[30:23] = 8'($urandom_range(250, 254));
                    y[30:23] = 8'($urandom_range(250, 254));
                    y[31] = x[31]; op = 1'b0;
                end
                4: begin
                    if ($urandom_range(0, 1) == 0) x[30:23] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
                    else y[30:23] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
                end
                5: y = x;
                default: ;
            endcase
            model(x, y, op, r_m, o_m, u_m, lat_m);
            start_op(x, y, op);
            wait_ready(lat);
            n_checks++;
            if (lat !== lat_m) begin
                n_fail++;
                $display("FAIL rnd%0d_latency: x=%h y=%h op=%b got %0d expected %0d", i, x, y, op, lat, lat_m);
            end
            n_checks++;
            if (result !== r_m) begin
                n_fail++;
                $display("FAIL rnd%0d_result: x=%h y=%h op=%b got %h expected %h", i, x, y, op, result, r_m);
            end
            n_checks++;
            if ({overflow_flag, underflow_flag} !== {o_m, u_m}) begin
                n_fail++;
                $display("FAIL rnd%0d_flags: x=%h y=%h op=%b got %b%b expected %b%b", i, x, y, op,
                         overflow_flag, underflow_flag, o_m, u_m);
            end
            do_ack();
            n_checks++;
            if (ready_add_subt !== 1'b0) begin
                n_fail++;
                $display("FAIL rnd%0d_ready_drop: got %b expected 0", i, ready_add_subt);
            end
        end
    endtask

    task automatic test_hold();
        int lat;
        start_op(32'h3FC00000, 32'h40100000, 1'b0);
        wait_ready(lat);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (ready_add_subt !== 1'b1 || result !== 32'h40700000) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: got ready=%b result=%h expected 1 40700000", c,
                         ready_add_subt, result);
            end
        end
        do_ack();
    endtask

    task automatic test_beg_ignored();
        logic [31:0] r_m; logic o_m, u_m; int lat_m, lat;
        model(32'h3F800000, 32'h35800000, 1'b0, r_m, o_m, u_m, lat_m);
        start_op(32'h3F800000, 32'h35800000, 1'b0);
        repeat (3) @(posedge clk);
        // Mid-ALIGN: a new request and a stray ack must both be ignored.
        @(negedge clk);
        beg_add_subt = 1'b1; ack_add_subt = 1'b1;
        Data_X = 32'h40400000; Data_Y = 32'h40400000; add_subt = 1'b1;
        @(negedge clk);
        beg_add_subt = 1'b0; ack_add_subt = 1'b0;
        wait_ready(lat);
        n_checks++;
        if (lat < 0 || result !== r_m || overflow_flag !== o_m || underflow_flag !== u_m) begin
            n_fail++;
            $display("FAIL beg_ignored: got wait=%0d result=%h expected %h", lat, result, r_m);
        end
        do_ack();
    endtask

    task automatic test_reset_mid();
        int lat;
        start_op(32'h3F800000, 32'h3A000000, 1'b0);
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({ready_add_subt, result, overflow_flag, underflow_flag} !== 35'h0) begin
            n_fail++;
            $display("FAIL reset_mid_align: got ready=%b result=%h ovf=%b unf=%b expected all zero",
                     ready_add_subt, result, overflow_flag, underflow_flag);
        end
        @(negedge clk); reset_n = 1'b1;
        start_op(32'h3F800000, 32'h3F400000, 1'b1);
        wait_ready(lat);
        n_checks++;
        if (lat !== 7 || result !== 32'h3E800000) begin
            n_fail++;
            $display("FAIL reset_then_op: got lat=%0d result=%h expected 7 3E800000", lat, result);
        end
        do_ack();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_hold();
        test_beg_ignored();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
